// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC selection and fetch-control sequencer
//
// Each cycle this block picks the next PC and drives the PC-register stall. It also
// produces the IF/ID and ID/EX flush/bubble controls and registers the trap return PC.
// The per-cycle outputs are combinational from the inputs and state. state, epc and the
// flush counter are registered.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   pc                current PC register value
//   jump/jump_target  unconditional jump decoded in ID
//   branch_taken/branch_target  taken branch resolved in EX
//   trap_req          exception/interrupt request (level)
//   load_use_hazard   ID depends on a load currently in EX
//   imem_ready        instruction memory has valid data for pc
//   halt              halt instruction in ID
//   pc_next           next value for the PC register
//   pc_stall          PC register stall / IF/ID hold enable
//   flush_ifid        IF/ID becomes NOP
//   flush_idex        ID/EX becomes NOP (bubble)
//   trap_ack          trap accepted this cycle
//   epc               return PC of the last accepted trap
//   state             0 RUN, 1 FLUSH, 2 HALT
module pc_sequencer #(
    parameter int              BUS_WIDTH    = 16,
    parameter int              PC_STEP      = 1,
    parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = 16'h0000,
    parameter logic [BUS_WIDTH-1:0] TRAP_VECTOR  = 16'h0004,
    parameter int              FLUSH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] pc,
    input  logic                 jump,
    input  logic [BUS_WIDTH-1:0] jump_target,
    input  logic                 branch_taken,
    input  logic [BUS_WIDTH-1:0] branch_target,
    input  logic                 trap_req,
    input  logic                 load_use_hazard,
    input  logic                 imem_ready,
    input  logic                 halt,
    output logic [BUS_WIDTH-1:0] pc_next,
    output logic                 pc_stall,
    output logic                 flush_ifid,
    output logic                 flush_idex,
    output logic                 trap_ack,
    output logic [BUS_WIDTH-1:0] epc,
    output logic [1:0]           state
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    // The counter only ever holds FLUSH_CYCLES-1 down to 0.
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 1) : '0;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] epc_q, epc_d;
    logic [BUS_WIDTH-1:0] seq_pc;
    logic                 redirect;

    // Wraps modulo 2^BUS_WIDTH by truncation.
    assign seq_pc = pc + BUS_WIDTH'(PC_STEP);

    always_comb begin
        pc_next    = seq_pc;
        pc_stall   = 1'b0;
        flush_ifid = (state_q == ST_FLUSH);
        flush_idex = 1'b0;
        trap_ack   = 1'b0;
        redirect   = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        epc_d      = epc_q;

        if (rst) begin
            pc_next    = RESET_VECTOR;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            state_d    = ST_RUN;
            cnt_d      = '0;
            epc_d      = '0;
        end else if (trap_req) begin
            pc_next    = TRAP_VECTOR;
            trap_ack   = 1'b1;
            epc_d      = pc;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            redirect   = 1'b1;
        end else if (state_q == ST_HALT) begin
            // Only a trap or reset leaves HALT; everything else is ignored here.
            pc_stall   = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (branch_taken) begin
            pc_next    = branch_target;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            redirect   = 1'b1;
        end else if (jump) begin
            // The jump itself is in ID and proceeds to EX, so ID/EX is kept.
            pc_next    = jump_target;
            flush_ifid = 1'b1;
            redirect   = 1'b1;
        end else if (halt) begin
            pc_stall   = 1'b1;
            flush_ifid = 1'b1;
            state_d    = ST_HALT;
            cnt_d      = '0;
        end else if (load_use_hazard) begin
            // Hold the ID instruction and bubble EX; takes precedence over an imem stall.
            pc_stall   = 1'b1;
            flush_ifid = 1'b0;
            flush_idex = 1'b1;
        end else if (!imem_ready) begin
            pc_stall   = 1'b1;
            flush_ifid = 1'b1;
        end else if (state_q == ST_FLUSH) begin
            // Counter steps only on cycles that actually fetch.
            if (cnt_q <= CNT_W'(1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q - CNT_W'(1);
            end
        end

        if (redirect) begin
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = CNT_LOAD;
            end else begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
        end
    end

    assign epc   = epc_q;
    assign state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - bench for pc_sequencer with FLUSH_CYCLES = 1, 2, 3 instances
module tb_pc_sequencer;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        jump;
    logic [15:0] jump_target;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        trap_req;
    logic        load_use_hazard;
    logic        imem_ready;
    logic        halt;

    logic [15:0] pc_next_w    [NI];
    logic        pc_stall_w   [NI];
    logic        flush_ifid_w [NI];
    logic        flush_idex_w [NI];
    logic        trap_ack_w   [NI];
    logic [15:0] epc_w        [NI];
    logic [1:0]  state_w      [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pc_sequencer #(.FLUSH_CYCLES(g + 1)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .pc             (pc),
            .jump           (jump),
            .jump_target    (jump_target),
            .branch_taken   (branch_taken),
            .branch_target  (branch_target),
            .trap_req       (trap_req),
            .load_use_hazard(load_use_hazard),
            .imem_ready     (imem_ready),
            .halt           (halt),
            .pc_next        (pc_next_w[g]),
            .pc_stall       (pc_stall_w[g]),
            .flush_ifid     (flush_ifid_w[g]),
            .flush_idex     (flush_idex_w[g]),
            .trap_ack       (trap_ack_w[g]),
            .epc            (epc_w[g]),
            .state          (state_w[g])
        );
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: "halted" flag, number of FLUSH cycles still owed, and the saved return PC.
    bit          m_halt [NI] = '{default: 1'b0};
    int          m_left [NI] = '{default: 0};
    logic [15:0] m_epc  [NI] = '{default: 16'h0};
    bit          n_halt [NI];
    int          n_left [NI];
    logic [15:0] n_epc  [NI];

    logic [15:0] e_pc;
    logic        e_st, e_fi, e_fx, e_ta;
    logic [1:0]  e_state;
    int          fc;

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            fc        = k + 1;
            e_state   = m_halt[k] ? 2'd2 : ((m_left[k] > 0) ? 2'd1 : 2'd0);
            e_pc      = 16'((32'(pc) + 1) % 65536);
            e_st      = 1'b0;
            e_fi      = (m_left[k] > 0);
            e_fx      = 1'b0;
            e_ta      = 1'b0;
            n_halt[k] = m_halt[k];
            n_left[k] = m_left[k];
            n_epc[k]  = m_epc[k];
            if (rst) begin
                e_pc = 16'h0000; e_fi = 1; e_fx = 1;
                n_halt[k] = 0; n_left[k] = 0; n_epc[k] = 16'h0;
            end else if (trap_req) begin
                e_pc = 16'h0004; e_ta = 1; e_fi = 1; e_fx = 1;
                n_epc[k] = pc; n_halt[k] = 0; n_left[k] = fc - 1;
            end else if (m_halt[k]) begin
                e_st = 1; e_fi = 1; e_fx = 1;
            end else if (branch_taken) begin
                e_pc = branch_target; e_fi = 1; e_fx = 1; n_left[k] = fc - 1;
            end else if (jump) begin
                e_pc = jump_target; e_fi = 1; e_fx = 0; n_left[k] = fc - 1;
            end else if (halt) begin
                e_st = 1; e_fi = 1; n_halt[k] = 1; n_left[k] = 0;
            end else if (load_use_hazard) begin
                e_st = 1; e_fi = 0; e_fx = 1;
            end else if (!imem_ready) begin
                e_st = 1; e_fi = 1;
            end else if (m_left[k] > 0) begin
                n_left[k] = m_left[k] - 1;
            end
            chk($sformatf("u%0d.pc_next", k),    32'(pc_next_w[k]),    32'(e_pc));
            chk($sformatf("u%0d.pc_stall", k),   32'(pc_stall_w[k]),   32'(e_st));
            chk($sformatf("u%0d.flush_ifid", k), 32'(flush_ifid_w[k]), 32'(e_fi));
            chk($sformatf("u%0d.flush_idex", k), 32'(flush_idex_w[k]), 32'(e_fx));
            chk($sformatf("u%0d.trap_ack", k),   32'(trap_ack_w[k]),   32'(e_ta));
            chk($sformatf("u%0d.epc", k),        32'(epc_w[k]),        32'(m_epc[k]));
            chk($sformatf("u%0d.state", k),      32'(state_w[k]),      32'(e_state));
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            m_halt[k] <= n_halt[k];
            m_left[k] <= n_left[k];
            m_epc[k]  <= n_epc[k];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        jump = 0; branch_taken = 0; trap_req = 0; load_use_hazard = 0; halt = 0;
        imem_ready = 1;
    endtask

    initial begin
        rst = 1; pc = 16'h0123; jump_target = 16'h0; branch_target = 16'h0;
        clear_ctl();

        // Reset held two cycles
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lit_rst_pc_next", 32'(pc_next_w[0]), 32'h0000);
            chk("lit_rst_flush_ifid", 32'(flush_ifid_w[0]), 32'h1);
            chk("lit_rst_flush_idex", 32'(flush_idex_w[0]), 32'h1);
            chk("lit_rst_state", 32'(state_w[0]), 32'h0);
            chk("lit_rst_epc", 32'(epc_w[0]), 32'h0);
            next_cycle();
        end

        // Sequential fetch and wrap
        rst = 0; pc = 16'h0010;
        @(negedge clk);
        chk("lit_seq_pc_next", 32'(pc_next_w[0]), 32'h0011);
        chk("lit_seq_stall", 32'(pc_stall_w[0]), 32'h0);
        next_cycle();
        pc = 16'hFFFF;
        @(negedge clk);
        chk("lit_wrap_pc_next", 32'(pc_next_w[0]), 32'h0000);
        next_cycle();

        // Branch beats jump in the same cycle
        pc = 16'h0030; branch_taken = 1; branch_target = 16'h0040; jump = 1; jump_target = 16'h0080;
        @(negedge clk);
        chk("lit_br_pc_next", 32'(pc_next_w[1]), 32'h0040);
        chk("lit_br_flush_ifid", 32'(flush_ifid_w[1]), 32'h1);
        chk("lit_br_flush_idex", 32'(flush_idex_w[1]), 32'h1);
        next_cycle();
        clear_ctl(); pc = 16'h0040;
        @(negedge clk);
        chk("lit_fc2_state_flush", 32'(state_w[1]), 32'h1);
        chk("lit_fc1_state_run", 32'(state_w[0]), 32'h0);
        next_cycle();
        pc = 16'h0041;
        @(negedge clk);
        chk("lit_fc2_state_back", 32'(state_w[1]), 32'h0);
        chk("lit_fc3_state_flush", 32'(state_w[2]), 32'h1);
        next_cycle();
        pc = 16'h0042;
        next_cycle();

        // Hazard vs. imem stall
        load_use_hazard = 1; imem_ready = 0;
        @(negedge clk);
        chk("lit_haz_stall", 32'(pc_stall_w[0]), 32'h1);
        chk("lit_haz_idex", 32'(flush_idex_w[0]), 32'h1);
        chk("lit_haz_ifid", 32'(flush_ifid_w[0]), 32'h0);
        next_cycle();
        load_use_hazard = 0;
        @(negedge clk);
        chk("lit_imem_ifid", 32'(flush_ifid_w[0]), 32'h1);
        chk("lit_imem_idex", 32'(flush_idex_w[0]), 32'h0);
        next_cycle();
        imem_ready = 1;

        // Halt, ignore a branch pulse, exit through trap
        pc = 16'h0022; halt = 1;
        @(negedge clk);
        chk("lit_halt_stall", 32'(pc_stall_w[0]), 32'h1);
        next_cycle();
        halt = 0;
        for (int i = 0; i < 5; i++) begin
            branch_taken = (i == 2); branch_target = 16'h0050;
            @(negedge clk);
            chk("lit_halt_hold_stall", 32'(pc_stall_w[0]), 32'h1);
            chk("lit_halt_state", 32'(state_w[0]), 32'h2);
            next_cycle();
        end
        branch_taken = 0; trap_req = 1;
        @(negedge clk);
        chk("lit_trap_pc_next", 32'(pc_next_w[0]), 32'h0004);
        chk("lit_trap_ack", 32'(trap_ack_w[0]), 32'h1);
        next_cycle();
        trap_req = 0; pc = 16'h0004;
        @(negedge clk);
        chk("lit_trap_epc", 32'(epc_w[0]), 32'h0022);
        chk("lit_trap_state_fc1", 32'(state_w[0]), 32'h0);
        chk("lit_trap_state_fc2", 32'(state_w[1]), 32'h1);
        next_cycle();
        pc = 16'h0005;
        next_cycle();
        next_cycle();

        // Reset in the middle of FLUSH (FLUSH_CYCLES=3, counter loaded with 2)
        jump = 1; jump_target = 16'h0100;
        next_cycle();
        jump = 0; pc = 16'h0100; rst = 1;
        @(negedge clk);
        chk("lit_midflush_state", 32'(state_w[2]), 32'h1);
        chk("lit_midflush_rst_pc", 32'(pc_next_w[2]), 32'h0000);
        next_cycle();
        rst = 0; pc = 16'h0000;
        @(negedge clk);
        chk("lit_after_rst_state", 32'(state_w[2]), 32'h0);
        chk("lit_after_rst_pc", 32'(pc_next_w[2]), 32'h0001);
        chk("lit_after_rst_ifid", 32'(flush_ifid_w[2]), 32'h0);
        next_cycle();

        // Mixed vectors, checked by the model
        for (int i = 0; i < 300; i++) begin
            rst             = ($urandom_range(0, 39) == 0);
            trap_req        = ($urandom_range(0, 19) == 0);
            branch_taken    = ($urandom_range(0, 7) == 0);
            jump            = ($urandom_range(0, 7) == 0);
            halt            = ($urandom_range(0, 24) == 0);
            load_use_hazard = ($urandom_range(0, 5) == 0);
            imem_ready      = ($urandom_range(0, 4) != 0);
            pc              = 16'($urandom);
            jump_target     = 16'($urandom);
            branch_target   = 16'($urandom);
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
